mem_arbiter: RTL

Shares the single-port memory controller between the instruction fetcher and the load/store buffer (LSB). It arbitrates the two request streams and drives the controller's `status_signal`, address and store-data inputs. It returns completed words to the right requester and discards in-flight fetch/load results on a pipeline flush. It sits between fetch/LSB and `memory_controller` in the CPU top level.

---
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction fetcher and the load/store buffer onto the single-port memory controller.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_data,
  input  logic        lsb_req,
  input  logic        lsb_we,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_valid,
  output logic [31:0] lsb_rdata,
  output logic [1:0]  mc_status,
  output logic [31:0] mc_instr_a,
  input  logic [31:0] mc_instr_d,
  input  logic        mc_instr_done,
  output logic [31:0] mc_lsb_addr,
  output logic [31:0] mc_lsb_din,
  input  logic [31:0] mc_lsb_dout,
  input  logic        mc_lsb_done
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 2;

  localparam logic [SW-1:0] ST_IDLE  = 2'b00;
  localparam logic [SW-1:0] ST_STORE = 2'b01;
  localparam logic [SW-1:0] ST_LOAD  = 2'b10;
  localparam logic [SW-1:0] ST_FETCH = 2'b11;

  if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic          if_valid_q, if_valid_d;
  logic [DW-1:0] if_data_q, if_data_d;
  logic          lsb_valid_q, lsb_valid_d;
  logic [DW-1:0] lsb_rdata_q, lsb_rdata_d;
  logic [SW-1:0] mc_status_q, mc_status_d;
  logic [AW-1:0] mc_instr_a_q, mc_instr_a_d;
  logic [AW-1:0] mc_lsb_addr_q, mc_lsb_addr_d;
  logic [DW-1:0] mc_lsb_din_q, mc_lsb_din_d;
  logic          fetch_ok, lsb_ok, fetch_first, drain_done;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CW = 4;
  logic [CW-1:0] starve_q, starve_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    if_valid_d    = 1'b0;
    lsb_valid_d   = 1'b0;
    if_data_d     = if_data_q;
    lsb_rdata_d   = lsb_rdata_q;
    mc_status_d   = mc_status_q;
    mc_instr_a_d  = mc_instr_a_q;
    mc_lsb_addr_d = mc_lsb_addr_q;
    mc_lsb_din_d  = mc_lsb_din_q;
    // A requester still seeing its own valid pulse has not dropped its request yet
    fetch_ok   = if_req  && !if_valid_q  && !flush_in;
    lsb_ok     = lsb_req && !lsb_valid_q && !flush_in;
    drain_done = (mc_status_q == ST_FETCH) ? mc_instr_done : mc_lsb_done;
`ifdef MEM_ARB_STARVE_GUARD_EN
    starve_d    = starve_q;
    fetch_first = fetch_ok && (!lsb_ok || (starve_q == CW'(STARVE_LIMIT) && if_req));
`else
    fetch_first = fetch_ok && !lsb_ok;
`endif

    case (state_q)
      S_IDLE: begin
        if (fetch_first) begin
          state_d      = S_FETCH;
          mc_status_d  = ST_FETCH;
          mc_instr_a_d = if_addr;
`ifdef MEM_ARB_STARVE_GUARD_EN
          starve_d     = '0;
`endif
        end else if (lsb_ok) begin
          mc_lsb_addr_d = lsb_addr;
          if (lsb_we) begin
            state_d      = S_STORE;
            mc_status_d  = ST_STORE;
            mc_lsb_din_d = lsb_wdata;
          end else begin
            state_d     = S_LOAD;
            mc_status_d = ST_LOAD;
          end
`ifdef MEM_ARB_STARVE_GUARD_EN
          if (if_req && starve_q != '1) starve_d = CW'(starve_q + 1'b1);
`endif
        end
      end
      S_FETCH: begin
        if (mc_instr_done) begin
          state_d     = S_IDLE;
          mc_status_d = ST_IDLE;
          if (!flush_in) begin
            if_valid_d = 1'b1;
            if_data_d  = mc_instr_d;
          end
        end else if (flush_in) begin
          state_d = S_DRAIN;
        end
      end
      S_LOAD: begin
        if (mc_lsb_done) begin
          state_d     = S_IDLE;
          mc_status_d = ST_IDLE;
          if (!flush_in) begin
            lsb_valid_d = 1'b1;
            lsb_rdata_d = mc_lsb_dout;
          end
        end else if (flush_in) begin
          state_d = S_DRAIN;
        end
      end
      S_STORE: begin
        // Committed stores ignore flush
        if (mc_lsb_done) begin
          state_d     = S_IDLE;
          mc_status_d = ST_IDLE;
          lsb_valid_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_d     = S_IDLE;
          mc_status_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        mc_status_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; rdy_in low freezes everything
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= S_IDLE;
      if_valid_q    <= 1'b0;
      if_data_q     <= '0;
      lsb_valid_q   <= 1'b0;
      lsb_rdata_q   <= '0;
      mc_status_q   <= ST_IDLE;
      mc_instr_a_q  <= '0;
      mc_lsb_addr_q <= '0;
      mc_lsb_din_q  <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_q      <= '0;
`endif
    end else if (rdy_in) begin
      state_q       <= state_d;
      if_valid_q    <= if_valid_d;
      if_data_q     <= if_data_d;
      lsb_valid_q   <= lsb_valid_d;
      lsb_rdata_q   <= lsb_rdata_d;
      mc_status_q   <= mc_status_d;
      mc_instr_a_q  <= mc_instr_a_d;
      mc_lsb_addr_q <= mc_lsb_addr_d;
      mc_lsb_din_q  <= mc_lsb_din_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_q      <= starve_d;
`endif
    end
  end

  assign if_valid    = if_valid_q;
  assign if_data     = if_data_q;
  assign lsb_valid   = lsb_valid_q;
  assign lsb_rdata   = lsb_rdata_q;
  assign mc_status   = mc_status_q;
  assign mc_instr_a  = mc_instr_a_q;
  assign mc_lsb_addr = mc_lsb_addr_q;
  assign mc_lsb_din  = mc_lsb_din_q;

endmodule
